// File: rtl/chacha_word_stream.sv
// ChaCha keystream word streamer: requests 512-bit blocks, ping-pong buffers them,
// and drains each as sixteen 32-bit words over a valid/ready handshake.
module chacha_word_stream #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    output logic         blk_req,
    input  logic         blk_done,
    input  logic [511:0] blk_data,
    output logic         word_valid,
    input  logic         word_ready,
    output logic [31:0]  word_data,
    output logic         word_last,
    output logic [31:0]  blk_count,
    output logic         timeout,
    output logic         spurious
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BLK_W  = 512;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               capture;
    logic               expire;
    logic [1:0]         full;
    logic               wr_sel;
    logic               rd_sel;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   wait_cnt;
    logic               handshake;
    logic [BLK_W-1:0]   blk_buf [2];

    // Request FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request FSM next state; a block in flight is always captured, even if enable drops
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        expire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !full[wr_sel]) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (blk_done) begin
                    state_d = IDLE;
                    capture = 1'b1;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_d = REQ;
                    expire  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign blk_req    = (state_q == REQ);
    assign handshake  = word_valid && word_ready;
    assign word_valid = full[rd_sel];
    assign word_last  = full[rd_sel] && (idx == IDX_W'(15));
    assign word_data  = full[rd_sel] ? blk_buf[rd_sel][{idx, 5'd0} +: WORD_W] : '0;

    // Buffer storage carries no reset; the full flags qualify its contents
    always_ff @(posedge clk) begin
        if (capture) begin
            blk_buf[wr_sel] <= blk_data;
        end
    end

    // Fill/drain bookkeeping; capture and release always target different buffers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full      <= '0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            idx       <= '0;
            wait_cnt  <= '0;
            blk_count <= '0;
            timeout   <= 1'b0;
            spurious  <= 1'b0;
        end else begin
            if (state_q == REQ) begin
                wait_cnt <= '0;
            end else if (state_q == WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (capture) begin
                full[wr_sel] <= 1'b1;
                wr_sel       <= ~wr_sel;
            end
            if (handshake) begin
                if (idx == IDX_W'(15)) begin
                    full[rd_sel] <= 1'b0;
                    rd_sel       <= ~rd_sel;
                    idx          <= '0;
                    blk_count    <= blk_count + 32'd1;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
            if (expire) begin
                timeout <= 1'b1;
            end
            if (blk_done && (state_q != WAIT)) begin
                spurious <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_chacha_word_stream.sv
// Scoreboard bench for chacha_word_stream: a core model delivers numbered blocks and
// a monitor checks every accepted word against the queued expectations.
module tb_chacha_word_stream;

    localparam int unsigned TMO = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         blk_req;
    logic         blk_done;
    logic [511:0] blk_data;
    logic         word_valid;
    logic         word_ready;
    logic [31:0]  word_data;
    logic         word_last;
    logic [31:0]  blk_count;
    logic         timeout;
    logic         spurious;

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int cd         = 0;
    bit core_on    = 1'b0;
    int blk_seq    = 0;
    int hs_count   = 0;
    int deliveries = 0;
    int t_base     = 0;
    logic [32:0] sb [$];
    int req_cyc [$];

    chacha_word_stream #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .blk_req    (blk_req),
        .blk_done   (blk_done),
        .blk_data   (blk_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_last  (word_last),
        .blk_count  (blk_count),
        .timeout    (timeout),
        .spurious   (spurious)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Block n carries word i = n*0x100 + i; block 0 is 0x00..0x0F
    task automatic deliver();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) begin
            d[32*i +: 32] = 32'(blk_seq * 256 + i);
            sb.push_back({(i == 15), 32'(blk_seq * 256 + i)});
        end
        blk_data = d;
        blk_done = 1'b1;
        blk_seq++;
        deliveries++;
    endtask

    // Advance one cycle, then act as the core: answer each request 3 cycles later
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        blk_done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) deliver();
        end
        if (blk_req) begin
            req_cyc.push_back(cyc);
            if (core_on) cd = 3;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        blk_done   = 1'b0;
        cd         = 0;
        sb.delete();
        req_cyc.delete();
        hs_count   = 0;
        deliveries = 0;
        tick();
        tick();
        t_base = blk_seq * 256;
        rst    = 1'b0;
    endtask

    // Monitor: every accepted word must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && word_valid && word_ready) begin
            hs_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_unexpected actual=%h required=none at cycle %0d", word_data, cyc);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                check("mon_data", word_data, e[31:0]);
                check("mon_last", 32'(word_last), 32'(e[32]));
            end
        end
    end

    initial begin
        int  g;
        bit  ok;
        rst        = 1'b1;
        enable     = 1'b0;
        blk_done   = 1'b0;
        blk_data   = '0;
        word_ready = 1'b0;
        #2;
        check("rst_blk_req", 32'(blk_req), 0);
        check("rst_word_valid", 32'(word_valid), 0);
        check("rst_word_data", word_data, 0);
        check("rst_word_last", 32'(word_last), 0);
        check("rst_blk_count", blk_count, 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_spurious", 32'(spurious), 0);

        // Basic streaming with prefetch
        do_reset();
        enable = 1'b1; word_ready = 1'b1; core_on = 1'b1;
        g = 0;
        while (blk_count == 0 && g < 100) begin tick(); g++; end
        check("t1_count_first", blk_count, 1);
        check("t1_hs_at_count", 32'(hs_count), 16);
        ok = (req_cyc.size() >= 2) && (req_cyc[1] < cyc);
        check("t1_prefetch", 32'(ok), 1);
        enable = 1'b0;
        repeat (60) tick();
        check("t1_sb_empty", 32'(sb.size()), 0);
        check("t1_count_end", blk_count, 32'(deliveries));
        check("t1_timeout", 32'(timeout), 0);
        check("t1_spurious", 32'(spurious), 0);

        // Stalled consumer: two requests fill both buffers, then nothing
        do_reset();
        word_ready = 1'b0; enable = 1'b1; core_on = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (word_valid) begin
                check("t2_hold_data", word_data, 32'(t_base));
                check("t2_hold_last", 32'(word_last), 0);
            end
        end
        check("t2_req_pulses", 32'(req_cyc.size()), 2);
        check("t2_valid", 32'(word_valid), 1);
        enable = 1'b0; word_ready = 1'b1;
        repeat (50) tick();
        check("t2_sb_empty", 32'(sb.size()), 0);
        check("t2_count", blk_count, 2);

        // Unresponsive core: timeout and periodic re-requests, then a late answer
        do_reset();
        core_on = 1'b0; enable = 1'b1; word_ready = 1'b1;
        g = 0;
        while (req_cyc.size() < 3 && g < 100) begin tick(); g++; end
        check("t3_req_seen", 32'(req_cyc.size()), 3);
        check("t3_period_a", 32'(req_cyc[1] - req_cyc[0]), TMO + 1);
        check("t3_period_b", 32'(req_cyc[2] - req_cyc[1]), TMO + 1);
        check("t3_timeout", 32'(timeout), 1);
        enable = 1'b0;
        tick();
        tick();
        deliver();
        tick();
        check("t3_late_valid", 32'(word_valid), 1);
        check("t3_late_word0", word_data, 32'(t_base));
        repeat (20) tick();
        check("t3_sb_empty", 32'(sb.size()), 0);
        check("t3_count", blk_count, 1);

        // Spurious completion while idle
        do_reset();
        enable = 1'b0; core_on = 1'b0;
        tick();
        blk_done = 1'b1;
        blk_data = '1;
        tick();
        tick();
        check("t4_spurious", 32'(spurious), 1);
        check("t4_valid", 32'(word_valid), 0);
        repeat (5) tick();
        check("t4_valid_later", 32'(word_valid), 0);
        check("t4_count", blk_count, 0);
        check("t4_no_req", 32'(req_cyc.size()), 0);

        // Reset in the middle of a drain
        do_reset();
        enable = 1'b1; word_ready = 1'b1; core_on = 1'b1;
        g = 0;
        while (hs_count < 7 && g < 100) begin tick(); g++; end
        check("t5_at_word7", word_data, 32'(t_base + 7));
        rst = 1'b1;
        #1;
        check("t5_async_valid", 32'(word_valid), 0);
        check("t5_async_data", word_data, 0);
        check("t5_async_last", 32'(word_last), 0);
        check("t5_async_req", 32'(blk_req), 0);
        check("t5_async_count", blk_count, 0);
        do_reset();
        g = 0;
        while (!word_valid && g < 40) begin tick(); g++; end
        check("t5_restart_word0", word_data, 32'(t_base));
        g = 0;
        while (blk_count == 0 && g < 100) begin tick(); g++; end
        enable = 1'b0;
        repeat (60) tick();
        check("t5_sb_empty", 32'(sb.size()), 0);
        check("t5_count", blk_count, 32'(deliveries));

        // Block counter wrap
        force dut.blk_count = 32'hFFFF_FFFF;
        tick();
        release dut.blk_count;
        tick();
        check("t6_preload", blk_count, 32'hFFFF_FFFF);
        req_cyc.delete();
        enable = 1'b1;
        g = 0;
        while (req_cyc.size() == 0 && g < 20) begin tick(); g++; end
        enable = 1'b0;
        g = 0;
        while (blk_count == 32'hFFFF_FFFF && g < 60) begin tick(); g++; end
        check("t6_wrap", blk_count, 0);
        repeat (10) tick();
        check("t6_sb_empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chacha_word_stream.md
# chacha_word_stream

Downstream stage of the ChaCha keystream core in the random-number generator. Requests 512-bit blocks from the core with a one-cycle pulse, captures each finished block into a two-entry ping-pong buffer, and streams it out as sixteen 32-bit words over a valid/ready handshake. Prefetches the next block while the current one drains, so the consumer sees one word per cycle at steady state.

## Interface
- TIMEOUT, 1024: cycles to wait for `blk_done` after a request before re-requesting; range 2..65535.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  allows new block requests; level-sensitive.
- blk_req  out  1  one-cycle request pulse to the core's `valid` input.
- blk_done  in  1  core block-complete strobe; `blk_data` is valid in the same cycle.
- blk_data  in  512  finished keystream block from the core.
- word_valid  out  1  `word_data` holds a valid word.
- word_ready  in  1  consumer accepts the word.
- word_data  out  32  output word.
- word_last  out  1  high with word index 15 of a block.
- blk_count  out  32  blocks fully drained; wraps from 0xFFFFFFFF to 0.
- timeout  out  1  sticky; set when a request times out.
- spurious  out  1  sticky; set when `blk_done` arrives outside WAIT.

## Operation
- Buffers: `buf[0..1]`, each 512 bits with a `full` flag. `wr_sel` selects the next buffer to fill and `rd_sel` the buffer being drained. Both toggle after use.
- Request FSM:
  - IDLE -> REQ when `enable` and `!full[wr_sel]`.
  - REQ: drive `blk_req=1` for exactly one cycle, clear the wait counter, then go to WAIT.
  - WAIT -> IDLE on `blk_done`. Capture `blk_data` into `buf[wr_sel]`, set its `full` flag, and toggle `wr_sel`.
  - WAIT -> REQ when the wait counter reaches TIMEOUT-1 without `blk_done`. Set `timeout` in the same transition.
- Dropping `enable` does not abort WAIT. The outstanding block is still captured.
- `blk_done` in IDLE or REQ is ignored (no capture) and sets `spurious`.
- Drain:
  - `word_valid = full[rd_sel]`.
  - `word_data = buf[rd_sel][32*idx +: 32]` with 4-bit `idx`; word 0 is bits [31:0].
  - On each handshake (`word_valid && word_ready`), `idx` increments.
  - At idx=15 the handshake clears `full[rd_sel]`, resets `idx` to 0, toggles `rd_sel`, and increments `blk_count` (modulo 2^32).
- Simultaneous events:
  - A capture into one buffer and a last-word release of the other in the same cycle are both honoured.
  - A capture into the buffer being released in that same cycle cannot occur, because a request requires `!full[wr_sel]` at REQ entry.
- `word_data` and `word_last` hold stable while `word_valid && !word_ready`.

## Timing
- Reset values: `blk_req=0`, `word_valid=0`, `word_data=0`, `word_last=0`, `blk_count=0`, `timeout=0`, `spurious=0`, both `full=0`, `wr_sel=rd_sel=0`, `idx=0`, FSM in IDLE. Wait counter is 0 and buffer contents are don't-care.
- Reset mid-operation discards both buffers and any outstanding request. A `blk_done` arriving after reset release sets `spurious`.
- Request latency:
  - `enable` rises in cycle N with a free buffer -> `blk_req` is high in cycle N+1.
  - The next request can issue no earlier than 2 cycles after a capture.
- Capture -> `word_valid` high on the next cycle.
- Throughput:
  - 1 word/cycle while `word_ready=1`.
  - With both buffers full, no request issues until the last-word handshake.
  - After a release, IDLE->REQ takes 1 cycle.
- Timeout: re-request `blk_req` is high exactly TIMEOUT+1 cycles after the previous pulse.

## Test plan
- Reset, `enable=1`, model returns `blk_done` 3 cycles after each `blk_req` with `blk_data = {16 words 0x0F..0x00}`, `word_ready=1`:
  - words appear in order 0x00..0x0F;
  - `word_last` is high with 0x0F;
  - `blk_count=1` after the 16th handshake;
  - a second `blk_req` issues before the first block drains.
- `word_ready=0` for the first 40 cycles with `enable=1`:
  - exactly 2 `blk_req` pulses, then none;
  - `word_data` is held at word 0 of block 1 throughout.
- Core never answers, TIMEOUT=8:
  - `timeout` sets;
  - `blk_req` pulses repeat every 9 cycles;
  - a late `blk_done` is captured normally.
- Pulse `blk_done` while IDLE with `enable=0`:
  - `spurious=1`, `word_valid` stays 0, `blk_count=0`.
- Assert `rst` mid-drain at word 7:
  - all outputs return to their reset values asynchronously;
  - after release, the next block starts at word 0.
- Preload `blk_count` to 0xFFFFFFFF (force) and drain one block:
  - `blk_count` wraps to 0x00000000.
